// File: rtl/dsm_serial_tx.sv
// Purpose : serial programming master for the DSM control word; serialises a
//           WORD_W-bit word MSB first on sclk/sdata, framed by en.
// Latency : en rises 1 clk after accept; first sclk rise CLK_DIV clk later;
//           frame lasts 2*CLK_DIV*(WORD_W+1) clk; done pulses the clk after.
// Backpressure: in_ready is high only in IDLE; a word is taken on
//           in_valid & in_ready.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   in_data/in_valid  word to send plus its valid; in_ready accepts it
//   sclk, sdata, en   registered serial pins to the DSM shift register
//   busy              high whenever a frame is in progress
//   done              one-cycle pulse in the first idle cycle after a frame
module dsm_serial_tx #(
  parameter int WORD_W  = 9,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sclk,
  output logic              sdata,
  output logic              en,
  output logic              busy,
  output logic              done
);

  // The counter must reach 2*CLK_DIV-1 because HOLD spans a full sclk period.
  localparam int CNT_W = (CLK_DIV < 1) ? 1 : $clog2(2 * CLK_DIV);
  localparam int BIT_W = (WORD_W < 2) ? 1 : $clog2(WORD_W);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("dsm_serial_tx: CLK_DIV must be >= 1");
  end
  if (WORD_W < 1) begin : g_bad_word_w
    $error("dsm_serial_tx: WORD_W must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [WORD_W-1:0] sr, sr_n;
  logic              accept;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sr_n    = sr;
    accept  = in_valid && (state == IDLE);

    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SETUP;
          cnt_n   = '0;
          sr_n    = in_data;
        end
      end
      SETUP: begin
        if (cnt == HALF_LAST) begin
          state_n = SHIFT_HI;
          cnt_n   = '0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = HOLD;
          end else begin
            // Falling edge: next lower bit moves to the shift-register MSB.
            state_n = SHIFT_LO;
            bit_n   = bit_cnt + 1'b1;
            sr_n    = sr << 1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (cnt == HALF_LAST) begin
          state_n = SHIFT_HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        // A full sclk period low after the last rise keeps the frame at
        // 2*CLK_DIV*(WORD_W+1) cycles and gives generous hold time.
        if (cnt == FULL_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Pin registers are loaded from the next-state view so they change on the
  // same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      en      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      sr      <= sr_n;
      sclk    <= (state_n == SHIFT_HI);
      en      <= (state_n != IDLE);
      sdata   <= (state_n != IDLE) && sr_n[WORD_W-1];
      done    <= (state == HOLD) && (state_n == IDLE);
    end
  end

endmodule
